// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, decoded opcode/funct values and datapath select encodings
// shared by the multicycle control unit.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, FETCH_WAIT, DECODE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, MEM_ADDR,
      LW_RD, LW_WB, SW_WR, BRANCH, JUMP, EXC_EPC, EXC_RD, EXC_LD
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_J    = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   localparam logic [2:0] ULA_NONE = 3'b000;
   localparam logic [2:0] ULA_ADD  = 3'b001;
   localparam logic [2:0] ULA_SUB  = 3'b010;
   localparam logic [2:0] ULA_AND  = 3'b011;
   localparam logic [2:0] ULA_CMP  = 3'b111;

   localparam logic [1:0] IORD_PC  = 2'b00;
   localparam logic [1:0] IORD_ERR = 2'b01;
   localparam logic [1:0] IORD_ALU = 2'b10;

   localparam logic [1:0] PCSRC_ULA    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_MEM    = 2'b11;

   localparam logic [2:0] REGDST_RT = 3'b000;
   localparam logic [2:0] REGDST_RD = 3'b001;

   localparam logic [3:0] MTR_ALU  = 4'b0001;
   localparam logic [3:0] MTR_LOAD = 4'b1001;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_SE   = 2'b10;
   localparam logic [1:0] SRCB_SE_2 = 2'b11;

   localparam logic [1:0] ERR_OPCODE = 2'b00;
   localparam logic [1:0] ERR_OVF    = 2'b01;

   localparam logic [1:0] SS_WORD = 2'b00;

endpackage

// File: rtl/ctrl_unit_fsm.sv
// ctrl_unit_fsm: multicycle CPU control unit sequencing fetch/decode/execute/memory/write-back/exception.
// Inputs: clk, rst (async, active high), opcode/funct from IR, ula_overflow/ula_eq from Ula32.
// Outputs: pc_w and every crtl_* select/enable of the datapath; all forced to 0 while rst is high.
module ctrl_unit_fsm
   import ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       ula_overflow,
   input  logic       ula_eq,
   output logic       pc_w,
   output logic [1:0] crtl_pcsrc,
   output logic [1:0] crtl_error,
   output logic [1:0] crtl_iord,
   output logic [1:0] crtl_ss,
   output logic       crtl_memwrite,
   output logic       crtl_irwrite,
   output logic [2:0] crtl_regdst,
   output logic [3:0] crtl_memtoreg,
   output logic       crtl_regwrite,
   output logic       crtl_memDataRegWrite,
   output logic       crtl_rega,
   output logic       crtl_regb,
   output logic       crtl_aluout_w,
   output logic       crtl_epc_w,
   output logic       crtl_ulasrca,
   output logic [1:0] crtl_ulasrcb,
   output logic [2:0] crtl_ula
);

   localparam int CW = $clog2(MEM_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LOAD = CW'(MEM_WAIT - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    err_code, err_nxt;
   logic          done;

   assign done = cnt == '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH;
         cnt      <= '0;
         err_code <= ERR_OPCODE;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         err_code <= err_nxt;
      end
   end

   // Everything defaults to 0 and the decode is skipped during reset, so no
   // write strobe can leak out while rst is high.
   always_comb begin
      state_nxt            = state;
      cnt_nxt              = cnt;
      err_nxt              = err_code;
      pc_w                 = 1'b0;
      crtl_pcsrc           = PCSRC_ULA;
      crtl_error           = ERR_OPCODE;
      crtl_iord            = IORD_PC;
      crtl_ss              = SS_WORD;
      crtl_memwrite        = 1'b0;
      crtl_irwrite         = 1'b0;
      crtl_regdst          = REGDST_RT;
      crtl_memtoreg        = 4'b0000;
      crtl_regwrite        = 1'b0;
      crtl_memDataRegWrite = 1'b0;
      crtl_rega            = 1'b0;
      crtl_regb            = 1'b0;
      crtl_aluout_w        = 1'b0;
      crtl_epc_w           = 1'b0;
      crtl_ulasrca         = 1'b0;
      crtl_ulasrcb         = SRCB_B;
      crtl_ula             = ULA_NONE;
      if (!rst) begin
         case (state)
            FETCH: begin
               crtl_ulasrcb = SRCB_4;
               crtl_ula     = ULA_ADD;
               cnt_nxt      = WAIT_LOAD;
               state_nxt    = FETCH_WAIT;
            end
            FETCH_WAIT: begin
               crtl_ulasrcb = SRCB_4;
               crtl_ula     = ULA_ADD;
               if (!done) cnt_nxt = cnt - 1'b1;
               else begin
                  crtl_irwrite = 1'b1;
                  pc_w         = 1'b1;
                  state_nxt    = DECODE;
               end
            end
            DECODE: begin
               crtl_rega     = 1'b1;
               crtl_regb     = 1'b1;
               crtl_ulasrcb  = SRCB_SE_2;
               crtl_ula      = ULA_ADD;
               crtl_aluout_w = 1'b1;
               state_nxt = opcode == OP_R ? R_EXEC :
                           opcode == OP_ADDI ? ADDI_EXEC :
                           (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                           (opcode == OP_BEQ || opcode == OP_BNE) ? BRANCH :
                           opcode == OP_J ? JUMP : EXC_EPC;
               if (state_nxt == EXC_EPC) err_nxt = ERR_OPCODE;
            end
            R_EXEC: begin
               crtl_ulasrca  = 1'b1;
               crtl_aluout_w = 1'b1;
               crtl_ula = funct == FN_ADD ? ULA_ADD :
                          funct == FN_SUB ? ULA_SUB :
                          funct == FN_AND ? ULA_AND : ULA_NONE;
               // An unknown funct outranks overflow; AND never overflows.
               if (crtl_ula == ULA_NONE) begin
                  state_nxt = EXC_EPC;
                  err_nxt   = ERR_OPCODE;
               end else if (ula_overflow && funct != FN_AND) begin
                  state_nxt = EXC_EPC;
                  err_nxt   = ERR_OVF;
               end else state_nxt = R_WB;
            end
            R_WB: begin
               crtl_regdst   = REGDST_RD;
               crtl_memtoreg = MTR_ALU;
               crtl_regwrite = 1'b1;
               state_nxt     = FETCH;
            end
            ADDI_EXEC: begin
               crtl_ulasrca  = 1'b1;
               crtl_ulasrcb  = SRCB_SE;
               crtl_ula      = ULA_ADD;
               crtl_aluout_w = 1'b1;
               if (ula_overflow) begin
                  state_nxt = EXC_EPC;
                  err_nxt   = ERR_OVF;
               end else state_nxt = ADDI_WB;
            end
            ADDI_WB: begin
               crtl_memtoreg = MTR_ALU;
               crtl_regwrite = 1'b1;
               state_nxt     = FETCH;
            end
            MEM_ADDR: begin
               crtl_ulasrca  = 1'b1;
               crtl_ulasrcb  = SRCB_SE;
               crtl_ula      = ULA_ADD;
               crtl_aluout_w = 1'b1;
               cnt_nxt       = WAIT_LOAD;
               state_nxt     = opcode == OP_LW ? LW_RD : SW_WR;
            end
            LW_RD: begin
               crtl_iord = IORD_ALU;
               if (!done) cnt_nxt = cnt - 1'b1;
               else begin
                  crtl_memDataRegWrite = 1'b1;
                  state_nxt            = LW_WB;
               end
            end
            LW_WB: begin
               crtl_memtoreg = MTR_LOAD;
               crtl_regwrite = 1'b1;
               state_nxt     = FETCH;
            end
            SW_WR: begin
               crtl_iord     = IORD_ALU;
               crtl_memwrite = 1'b1;
               state_nxt     = FETCH;
            end
            BRANCH: begin
               crtl_ulasrca = 1'b1;
               crtl_ula     = ULA_CMP;
               crtl_pcsrc   = PCSRC_ALUOUT;
               pc_w         = opcode == OP_BEQ ? ula_eq : !ula_eq;
               state_nxt    = FETCH;
            end
            JUMP: begin
               pc_w       = 1'b1;
               crtl_pcsrc = PCSRC_JUMP;
               state_nxt  = FETCH;
            end
            EXC_EPC: begin
               crtl_ulasrcb = SRCB_4;
               crtl_ula     = ULA_SUB;
               crtl_epc_w   = 1'b1;
               cnt_nxt      = WAIT_LOAD;
               state_nxt    = EXC_RD;
            end
            EXC_RD: begin
               crtl_iord  = IORD_ERR;
               crtl_error = err_code;
               if (!done) cnt_nxt = cnt - 1'b1;
               else state_nxt = EXC_LD;
            end
            EXC_LD: begin
               crtl_iord  = IORD_ERR;
               pc_w       = 1'b1;
               crtl_pcsrc = PCSRC_MEM;
               state_nxt  = FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_unit_fsm.sv
// tb_ctrl_unit_fsm: two control units (MEM_WAIT 1 and 3) checked cycle by cycle against per-instruction output traces.
module tb_ctrl_unit_fsm;

   typedef struct packed {
      logic       pc_w;
      logic [1:0] pcsrc, error, iord, ss;
      logic       memwrite, irwrite;
      logic [2:0] regdst;
      logic [3:0] memtoreg;
      logic       regwrite, mdr, rega, regb, aluout_w, epc_w, srca;
      logic [1:0] srcb;
      logic [2:0] ula;
   } ctl_t;

   logic       clk = 1'b0;
   logic       rst [2] = '{1'b1, 1'b1};
   logic [5:0] opcode = 6'h00, funct = 6'h00;
   logic       ula_overflow = 1'b0, ula_eq = 1'b0;

   logic       pc_w [2], memwrite [2], irwrite [2], regwrite [2], mdr [2];
   logic       rega [2], regb [2], aluout_w [2], epc_w [2], srca [2];
   logic [1:0] pcsrc [2], error [2], iord [2], ss [2], srcb [2];
   logic [2:0] regdst [2], ula [2];
   logic [3:0] memtoreg [2];
   ctl_t       o [2];

   ctl_t e0[$], e1[$], g0[$], g1[$];
   int   total = 0, bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : duts
      ctrl_unit_fsm #(.MEM_WAIT(g == 0 ? 1 : 3)) u (
         .clk(clk), .rst(rst[g]), .opcode(opcode), .funct(funct),
         .ula_overflow(ula_overflow), .ula_eq(ula_eq),
         .pc_w(pc_w[g]), .crtl_pcsrc(pcsrc[g]), .crtl_error(error[g]), .crtl_iord(iord[g]),
         .crtl_ss(ss[g]), .crtl_memwrite(memwrite[g]), .crtl_irwrite(irwrite[g]),
         .crtl_regdst(regdst[g]), .crtl_memtoreg(memtoreg[g]), .crtl_regwrite(regwrite[g]),
         .crtl_memDataRegWrite(mdr[g]), .crtl_rega(rega[g]), .crtl_regb(regb[g]),
         .crtl_aluout_w(aluout_w[g]), .crtl_epc_w(epc_w[g]), .crtl_ulasrca(srca[g]),
         .crtl_ulasrcb(srcb[g]), .crtl_ula(ula[g])
      );
      assign o[g] = {pc_w[g], pcsrc[g], error[g], iord[g], ss[g], memwrite[g], irwrite[g],
                     regdst[g], memtoreg[g], regwrite[g], mdr[g], rega[g], regb[g],
                     aluout_w[g], epc_w[g], srca[g], srcb[g], ula[g]};
   end

   function automatic void put(int mw, ctl_t c);
      if (mw == 1) e0.push_back(c);
      else e1.push_back(c);
   endfunction

   function automatic ctl_t fetch_vec();
      ctl_t c = '0;
      c.srcb = 2'b01;
      c.ula  = 3'b001;
      return c;
   endfunction

   // Expected per-cycle outputs for one whole instruction, FETCH through the last state.
   function automatic void build(int mw, logic [5:0] op, logic [5:0] fn, logic ovf, logic eq);
      ctl_t c;
      bit exc = 0;
      logic [1:0] code = 2'b00;
      put(mw, fetch_vec());
      for (int i = 0; i < mw; i++) begin
         c = fetch_vec();
         if (i == mw - 1) begin c.irwrite = 1; c.pc_w = 1; end
         put(mw, c);
      end
      c = '0; c.rega = 1; c.regb = 1; c.srcb = 2'b11; c.ula = 3'b001; c.aluout_w = 1;
      put(mw, c);
      if (op == 6'h00) begin
         c = '0; c.srca = 1; c.aluout_w = 1;
         c.ula = fn == 6'h20 ? 3'b001 : fn == 6'h22 ? 3'b010 : fn == 6'h24 ? 3'b011 : 3'b000;
         put(mw, c);
         if (!(fn inside {6'h20, 6'h22, 6'h24})) exc = 1;
         else if (ovf && fn != 6'h24) begin exc = 1; code = 2'b01; end
         else begin c = '0; c.regdst = 3'b001; c.memtoreg = 4'b0001; c.regwrite = 1; put(mw, c); end
      end else if (op == 6'h08) begin
         c = '0; c.srca = 1; c.srcb = 2'b10; c.ula = 3'b001; c.aluout_w = 1;
         put(mw, c);
         if (ovf) begin exc = 1; code = 2'b01; end
         else begin c = '0; c.memtoreg = 4'b0001; c.regwrite = 1; put(mw, c); end
      end else if (op == 6'h23 || op == 6'h2B) begin
         c = '0; c.srca = 1; c.srcb = 2'b10; c.ula = 3'b001; c.aluout_w = 1;
         put(mw, c);
         if (op == 6'h23) begin
            for (int i = 0; i < mw; i++) begin
               c = '0; c.iord = 2'b10; c.mdr = (i == mw - 1);
               put(mw, c);
            end
            c = '0; c.memtoreg = 4'b1001; c.regwrite = 1; put(mw, c);
         end else begin
            c = '0; c.iord = 2'b10; c.memwrite = 1; put(mw, c);
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         c = '0; c.srca = 1; c.ula = 3'b111; c.pcsrc = 2'b01;
         c.pc_w = op == 6'h04 ? eq : !eq;
         put(mw, c);
      end else if (op == 6'h02) begin
         c = '0; c.pc_w = 1; c.pcsrc = 2'b10; put(mw, c);
      end else exc = 1;
      if (exc) begin
         c = '0; c.srcb = 2'b01; c.ula = 3'b010; c.epc_w = 1; put(mw, c);
         for (int i = 0; i < mw; i++) begin
            c = '0; c.iord = 2'b01; c.error = code; put(mw, c);
         end
         c = '0; c.iord = 2'b01; c.pc_w = 1; c.pcsrc = 2'b11; put(mw, c);
      end
   endfunction

   // Runs one instruction on both units from FETCH and records their outputs;
   // the faster unit is parked in reset until the slower one is back at FETCH.
   task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic eq);
      e0.delete(); e1.delete(); g0.delete(); g1.delete();
      build(1, op, fn, ovf, eq);
      build(3, op, fn, ovf, eq);
      opcode = op; funct = fn; ula_overflow = ovf; ula_eq = eq;
      #1;
      while (g0.size() < e0.size() || g1.size() < e1.size()) begin
         if (g0.size() < e0.size()) g0.push_back(o[0]); else rst[0] = 1'b1;
         if (g1.size() < e1.size()) g1.push_back(o[1]); else rst[1] = 1'b1;
         @(negedge clk); #1;
      end
      rst[0] = 1'b0; rst[1] = 1'b0;
   endtask

   task automatic test_reset();
      ctl_t lw_rd;
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (o[k] !== '0) begin bad++; $display("FAIL reset_hold mw=%0d got=%h exp=%h", k ? 3 : 1, o[k], ctl_t'('0)); end
      end
      rst[0] = 1'b0; rst[1] = 1'b0; #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (o[k] !== fetch_vec()) begin bad++; $display("FAIL reset_fetch mw=%0d got=%h exp=%h", k ? 3 : 1, o[k], fetch_vec()); end
      end
      opcode = 6'h23; funct = 6'h00; ula_overflow = 1'b0; ula_eq = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      lw_rd = '0; lw_rd.iord = 2'b10;
      total++;
      if (o[1] !== lw_rd) begin bad++; $display("FAIL reset_lw_rd got=%h exp=%h", o[1], lw_rd); end
      rst[0] = 1'b1; rst[1] = 1'b1; #1;
      total++;
      if (o[1] !== '0) begin bad++; $display("FAIL reset_mid_lw got=%h exp=%h", o[1], ctl_t'('0)); end
      @(negedge clk); #1;
      total++;
      if (o[1] !== '0) begin bad++; $display("FAIL reset_mid_lw_held got=%h exp=%h", o[1], ctl_t'('0)); end
      rst[0] = 1'b0; rst[1] = 1'b0; #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (o[k] !== fetch_vec()) begin bad++; $display("FAIL reset_release mw=%0d got=%h exp=%h", k ? 3 : 1, o[k], fetch_vec()); end
      end
   endtask

   task automatic test_add();
      exec(6'h00, 6'h20, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < (k ? e1.size() : e0.size()); i++) begin
            total++;
            if ((k ? g1[i] : g0[i]) !== (k ? e1[i] : e0[i])) begin
               bad++; $display("FAIL add mw=%0d cyc=%0d got=%h exp=%h", k ? 3 : 1, i, k ? g1[i] : g0[i], k ? e1[i] : e0[i]);
            end
         end
   endtask

   task automatic test_sub_overflow();
      exec(6'h00, 6'h22, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < (k ? e1.size() : e0.size()); i++) begin
            total++;
            if ((k ? g1[i] : g0[i]) !== (k ? e1[i] : e0[i])) begin
               bad++; $display("FAIL sub_ovf mw=%0d cyc=%0d got=%h exp=%h", k ? 3 : 1, i, k ? g1[i] : g0[i], k ? e1[i] : e0[i]);
            end
         end
   endtask

   task automatic test_lw();
      int n = 0;
      exec(6'h23, 6'h11, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < (k ? e1.size() : e0.size()); i++) begin
            total++;
            if ((k ? g1[i] : g0[i]) !== (k ? e1[i] : e0[i])) begin
               bad++; $display("FAIL lw mw=%0d cyc=%0d got=%h exp=%h", k ? 3 : 1, i, k ? g1[i] : g0[i], k ? e1[i] : e0[i]);
            end
         end
      foreach (g1[i]) n += int'(g1[i].iord == 2'b10);
      total++;
      if (n !== 3) begin bad++; $display("FAIL lw_read_cycles got=%0d exp=3", n); end
   endtask

   task automatic test_branch();
      for (int b = 0; b < 4; b++) begin
         exec(b[1] ? 6'h05 : 6'h04, 6'h00, 1'b0, b[0]);
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < (k ? e1.size() : e0.size()); i++) begin
               total++;
               if ((k ? g1[i] : g0[i]) !== (k ? e1[i] : e0[i])) begin
                  bad++; $display("FAIL branch op=%0d eq=%0d mw=%0d cyc=%0d got=%h exp=%h", b[1] ? 5 : 4, b[0], k ? 3 : 1, i, k ? g1[i] : g0[i], k ? e1[i] : e0[i]);
               end
            end
      end
   endtask

   task automatic test_invalid_and_sw();
      int n = 0;
      exec(6'h3F, 6'h20, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < (k ? e1.size() : e0.size()); i++) begin
            total++;
            if ((k ? g1[i] : g0[i]) !== (k ? e1[i] : e0[i])) begin
               bad++; $display("FAIL invalid mw=%0d cyc=%0d got=%h exp=%h", k ? 3 : 1, i, k ? g1[i] : g0[i], k ? e1[i] : e0[i]);
            end
         end
      exec(6'h2B, 6'h00, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < (k ? e1.size() : e0.size()); i++) begin
            total++;
            if ((k ? g1[i] : g0[i]) !== (k ? e1[i] : e0[i])) begin
               bad++; $display("FAIL sw mw=%0d cyc=%0d got=%h exp=%h", k ? 3 : 1, i, k ? g1[i] : g0[i], k ? e1[i] : e0[i]);
            end
         end
      foreach (g1[i]) n += int'(g1[i].memwrite);
      total++;
      if (n !== 1) begin bad++; $display("FAIL sw_memwrite_cycles got=%0d exp=1", n); end
   endtask

   task automatic test_random();
      logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
      logic [5:0] fns [3] = '{6'h20, 6'h22, 6'h24};
      for (int n = 0; n < 150; n++) begin
         int oi = int'($urandom_range(0, 9));
         int fi = int'($urandom_range(0, 3));
         logic [5:0] op = oi < 8 ? ops[oi] : 6'($urandom);
         logic [5:0] fn = fi < 3 ? fns[fi] : 6'($urandom);
         exec(op, fn, 1'($urandom), 1'($urandom));
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < (k ? e1.size() : e0.size()); i++) begin
               total++;
               if ((k ? g1[i] : g0[i]) !== (k ? e1[i] : e0[i])) begin
                  bad++; $display("FAIL random op=%h fn=%h mw=%0d cyc=%0d got=%h exp=%h", op, fn, k ? 3 : 1, i, k ? g1[i] : g0[i], k ? e1[i] : e0[i]);
               end
            end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_overflow();
      test_lw();
      test_branch();
      test_invalid_and_sw();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
